sr_cmd_gen: RTL and testbench
=============================

Name: sr_cmd_gen

Overview:
- Upstream command stage for the SR flip-flop.
- Turns two raw, asynchronous, bouncy pushbuttons (set, clear) into clean, synchronous, one-shot S and R pulses.
- Never drives S and R high together. Always inserts a dead cycle between pulses.
- S and R outputs connect directly to the flip-flop's S and R inputs; both blocks share CLK and rst.

Parameters:
- DEB_CYCLES, 4, consecutive cycles a synchronized input must differ from its debounced level before that level flips; legal range 1..255.
- PULSE_LEN, 1, cycles each S or R pulse is held high; legal range 1..15.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- set_btn  input  1  raw set button, asynchronous, active-high.
- clr_btn  input  1  raw clear button, asynchronous, active-high.
- S  output  1  set pulse to the flip-flop.
- R  output  1  reset pulse to the flip-flop.
- busy  output  1  high while in PULSE_S, PULSE_R or GAP.
- conflict  output  1  one-cycle flag: set and clear requests were dropped because they coincided.

Behaviour:
- Reset: rst is sampled at a CLK edge and is fully synchronous (clock one way, reset polarity and synchronicity as given here).
  - On reset, S=0, R=0, busy=0, conflict=0.
  - Synchronizer flops, debounced levels, debounce counters and pending flag all clear to 0. FSM goes to IDLE.
  - Reset asserted mid-pulse drops S/R at the same edge. Any pending request is discarded.
- Synchronizer: two flops per button (b1, then b2). The input value is first captured at edge E0 and appears on b2 at E1.
- Debounce: one counter per button, width ceil(log2(DEB_CYCLES+1)).
  - If b2 equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. On the edge where it would reach DEB_CYCLES, the debounced level takes b2 and the counter clears.
- Request: a request fires on a 0->1 transition of the debounced level, as a one-cycle registered strobe. Falling edges generate nothing.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP. A pulse-length counter runs within the PULSE states.
  - IDLE, set request only -> PULSE_S.
  - IDLE, clear request only -> PULSE_R.
  - IDLE, both requests in the same cycle -> stay in IDLE, conflict=1 for one cycle.
  - PULSE_S drives S=1 for exactly PULSE_LEN cycles, then -> GAP. PULSE_R is the same, with R=1.
  - GAP drives S=R=0 for exactly one cycle, then -> the pending pulse if one is stored, else IDLE.
- Pending slot (one deep):
  - A request arriving while busy=1 is stored.
  - A later request overwrites it (last wins).
  - Set and clear arriving together while busy: the slot is cleared and conflict=1.
- Latency: set_btn rises cleanly before E0 with DEB_CYCLES=4 -> debounced level flips at E5, strobe at E6, S=1 after E7.
  - General case: S/R rises after edge E(DEB_CYCLES+3).
- Invariants: S&R==0 on every cycle. There is at least one cycle with S=R=0 between any two pulses.
- A button held high produces exactly one pulse. Bounces shorter than DEB_CYCLES cycles at b2 produce no pulse.

Optional Feature:
- Macro: SR_CMD_TOGGLE_EN.
- Defined: adds ports tgl_btn (input, 1, raw toggle button) and q_fb (input, 1, the flip-flop's Q).
  - tgl_btn gets its own synchronizer, debouncer and request strobe.
  - A toggle request becomes a set request if q_fb=0, otherwise a clear request. q_fb is sampled in the strobe cycle.
  - A toggle request coinciding with any set or clear request is a conflict.
- Undefined: neither port exists and the toggle logic is absent. Behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 3 cycles with both buttons toggling -> S=R=busy=conflict=0 throughout. After release, all outputs stay 0 while the buttons are idle.
- Clean set, defaults: set_btn 0->1 before E0 and held 20 cycles -> S=1 for exactly 1 cycle after E7, busy=1 for 2 cycles. R stays 0. Only one pulse.
- Bounce rejection: set_btn toggled high 3 cycles, low 1, high 2, low thereafter -> no S pulse. Then held high 10 cycles -> one S pulse.
- Simultaneous press: set_btn and clr_btn rise in the same cycle -> S=R=0 and conflict=1 for exactly one cycle, 7 edges after E0.
- Back-to-back, PULSE_LEN=3: set press, then clear press timed so its strobe lands mid-PULSE_S -> S high 3 cycles, one GAP cycle, then R high 3 cycles. S&R never 1.
- Reset mid-pulse, PULSE_LEN=4: rst asserted during the 2nd S cycle with a clear pending -> S=0 at that edge. No R pulse follows after rst release.

Source files
------------

// File: rtl/sr_cmd_gen.sv
// Command generator for the SR flip-flop: synchronizes and debounces the set/clear buttons
// and emits exclusive one-shot S/R pulses with a dead cycle between them. Optional toggle button under SR_CMD_TOGGLE_EN.
module sr_cmd_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int PULSE_LEN  = 1
) (
  input  logic CLK,
  input  logic rst,
  input  logic set_btn,
  input  logic clr_btn,
`ifdef SR_CMD_TOGGLE_EN
  input  logic tgl_btn,
  input  logic q_fb,
`endif
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

`ifdef SR_CMD_TOGGLE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int CW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

  logic [NB-1:0] btn, b1, b2, lvl, lvl_d, req;
  logic [CW-1:0] cnt [NB];

  state_t     state;
  logic [3:0] pcnt;
  logic       pend_vld, pend_set;
  logic       rs, rc, set_c, clr_c, conf_c, launch, launch_set;

`ifdef SR_CMD_TOGGLE_EN
  assign btn = {tgl_btn, clr_btn, set_btn};
`else
  assign btn = {clr_btn, set_btn};
`endif

  // Synchronizer, debounce and rising-edge strobe, one lane per button
  always_ff @(posedge CLK) begin
    if (rst) begin
      b1    <= '0;
      b2    <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      req   <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      b1    <= btn;
      b2    <= b1;
      lvl_d <= lvl;
      req   <= lvl & ~lvl_d;
      for (int i = 0; i < NB; i++) begin
        if (b2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          lvl[i] <= b2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Request arbitration; a toggle resolves to set or clear from the flop's current Q
  always_comb begin
    rs = req[0];
    rc = req[1];
`ifdef SR_CMD_TOGGLE_EN
    conf_c = (rs & rc) | (req[2] & (rs | rc));
    set_c  = (rs | (req[2] & ~q_fb)) & ~conf_c;
    clr_c  = (rc | (req[2] &  q_fb)) & ~conf_c;
`else
    conf_c = rs & rc;
    set_c  = rs & ~rc;
    clr_c  = rc & ~rs;
`endif
    // A fresh request at the GAP edge wins over the stored one
    launch     = set_c | clr_c | (~conf_c & pend_vld);
    launch_set = set_c | (~clr_c & ~conf_c & pend_vld & pend_set);
  end

  // Pulse FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      S        <= 1'b0;
      R        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      pcnt     <= '0;
      pend_vld <= 1'b0;
      pend_set <= 1'b0;
    end else begin
      conflict <= conf_c;
      case (state)
        IDLE: begin
          pcnt <= '0;
          if (set_c) begin
            state <= PULSE_S;
            S     <= 1'b1;
            busy  <= 1'b1;
          end else if (clr_c) begin
            state <= PULSE_R;
            R     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        PULSE_S, PULSE_R: begin
          if (conf_c) begin
            pend_vld <= 1'b0;
          end else if (set_c | clr_c) begin
            pend_vld <= 1'b1;
            pend_set <= set_c;
          end
          if (pcnt == 4'(PULSE_LEN - 1)) begin
            state <= GAP;
            S     <= 1'b0;
            R     <= 1'b0;
          end else begin
            pcnt <= pcnt + 4'd1;
          end
        end
        GAP: begin
          pend_vld <= 1'b0;
          pcnt     <= '0;
          if (launch) begin
            state <= launch_set ? PULSE_S : PULSE_R;
            S     <= launch_set;
            R     <= ~launch_set;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          S     <= 1'b0;
          R     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: three instances (PULSE_LEN 1, 3, 4) driven per scenario,
// expected {S,R,busy,conflict} traces queued at stimulus time and popped every cycle.
module tb_sr_cmd_gen;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [2:0] rst, set_btn, clr_btn;
  wire  [2:0] S, R, busy, conflict;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exq[$];
  logic [3:0] e;
  logic chk_inv = 1'b0;

  localparam logic [3:0] P_S = 4'b1010, P_R = 4'b0110, P_G = 4'b0010, P_C = 4'b0001;

  sr_cmd_gen #(.DEB_CYCLES(4), .PULSE_LEN(1)) dut0 (
    .CLK(CLK), .rst(rst[0]), .set_btn(set_btn[0]), .clr_btn(clr_btn[0]),
`ifdef SR_CMD_TOGGLE_EN
    .tgl_btn(1'b0), .q_fb(1'b0),
`endif
    .S(S[0]), .R(R[0]), .busy(busy[0]), .conflict(conflict[0]));

  sr_cmd_gen #(.DEB_CYCLES(4), .PULSE_LEN(3)) dut1 (
    .CLK(CLK), .rst(rst[1]), .set_btn(set_btn[1]), .clr_btn(clr_btn[1]),
`ifdef SR_CMD_TOGGLE_EN
    .tgl_btn(1'b0), .q_fb(1'b0),
`endif
    .S(S[1]), .R(R[1]), .busy(busy[1]), .conflict(conflict[1]));

  sr_cmd_gen #(.DEB_CYCLES(4), .PULSE_LEN(4)) dut2 (
    .CLK(CLK), .rst(rst[2]), .set_btn(set_btn[2]), .clr_btn(clr_btn[2]),
`ifdef SR_CMD_TOGGLE_EN
    .tgl_btn(1'b0), .q_fb(1'b0),
`endif
    .S(S[2]), .R(R[2]), .busy(busy[2]), .conflict(conflict[2]));

  function automatic logic [3:0] obs(int k);
    return {S[k], R[k], busy[k], conflict[k]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) exq.push_back(4'b0000);
  endtask

  // S and R must never be high together on any instance
  always @(negedge CLK) begin
    if (chk_inv) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if ((S[k] & R[k]) !== 1'b0) begin
          n_bad++;
          $display("FAIL s_and_r dut%0d t=%0t: S=%b R=%b, required not both 1", k, $time, S[k], R[k]);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 3'b111;
    set_btn = 3'b000;
    clr_btn = 3'b111;
    push_idle(3 * 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        e = exq.pop_front();
        n_cmp++;
        if (obs(k) !== e) begin
          n_bad++;
          $display("FAIL reset_hold dut%0d cyc %0d: got %b want %b", k, i, obs(k), e);
        end
      end
      set_btn = ~set_btn;
      clr_btn = ~clr_btn;
    end
    rst = 3'b000;
    set_btn = 3'b000;
    clr_btn = 3'b000;
    push_idle(12 * 3);
    for (int i = 0; i < 12; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        e = exq.pop_front();
        n_cmp++;
        if (obs(k) !== e) begin
          n_bad++;
          $display("FAIL reset_idle dut%0d cyc %0d: got %b want %b", k, i, obs(k), e);
        end
      end
    end
  endtask

  task automatic test_clean_set();
    set_btn[0] = 1'b1;
    push_idle(30);
    exq[7] = P_S;
    exq[8] = P_G;
    for (int i = 0; i < 30; i++) begin
      tick();
      e = exq.pop_front();
      n_cmp++;
      if (obs(0) !== e) begin
        n_bad++;
        $display("FAIL clean_set cyc %0d: got %b want %b", i, obs(0), e);
      end
      if (i == 19) set_btn[0] = 1'b0;
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b0011_0111;
    set_btn[0] = pat[0];
    push_idle(20);
    for (int i = 0; i < 20; i++) begin
      tick();
      e = exq.pop_front();
      n_cmp++;
      if (obs(0) !== e) begin
        n_bad++;
        $display("FAIL bounce_reject cyc %0d: got %b want %b", i, obs(0), e);
      end
      set_btn[0] = (i + 1 < 8) ? pat[i + 1] : 1'b0;
    end
    set_btn[0] = 1'b1;
    push_idle(25);
    exq[7] = P_S;
    exq[8] = P_G;
    for (int i = 0; i < 25; i++) begin
      tick();
      e = exq.pop_front();
      n_cmp++;
      if (obs(0) !== e) begin
        n_bad++;
        $display("FAIL bounce_hold cyc %0d: got %b want %b", i, obs(0), e);
      end
      if (i == 9) set_btn[0] = 1'b0;
    end
  endtask

  task automatic test_conflict();
    set_btn[0] = 1'b1;
    clr_btn[0] = 1'b1;
    push_idle(25);
    exq[7] = P_C;
    for (int i = 0; i < 25; i++) begin
      tick();
      e = exq.pop_front();
      n_cmp++;
      if (obs(0) !== e) begin
        n_bad++;
        $display("FAIL conflict cyc %0d: got %b want %b", i, obs(0), e);
      end
      if (i == 11) begin
        set_btn[0] = 1'b0;
        clr_btn[0] = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    set_btn[1] = 1'b1;
    push_idle(32);
    for (int j = 7; j <= 9; j++) exq[j] = P_S;
    exq[10] = P_G;
    for (int j = 11; j <= 13; j++) exq[j] = P_R;
    exq[14] = P_G;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = exq.pop_front();
      n_cmp++;
      if (obs(1) !== e) begin
        n_bad++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs(1), e);
      end
      if (i == 1) clr_btn[1] = 1'b1;
      if (i == 19) begin
        set_btn[1] = 1'b0;
        clr_btn[1] = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    set_btn[2] = 1'b1;
    push_idle(30);
    exq[7] = P_S;
    exq[8] = P_S;
    for (int i = 0; i < 30; i++) begin
      tick();
      e = exq.pop_front();
      n_cmp++;
      if (obs(2) !== e) begin
        n_bad++;
        $display("FAIL reset_mid_pulse cyc %0d: got %b want %b", i, obs(2), e);
      end
      if (i == 0) clr_btn[2] = 1'b1;
      if (i == 8) begin
        rst[2] = 1'b1;
        set_btn[2] = 1'b0;
        clr_btn[2] = 1'b0;
      end
      if (i == 9) rst[2] = 1'b0;
    end
  endtask

  initial begin
    rst = 3'b111;
    set_btn = 3'b000;
    clr_btn = 3'b000;
    test_reset();
    chk_inv = 1'b1;
    test_clean_set();
    test_bounce();
    test_conflict();
    test_back_to_back();
    test_reset_mid_pulse();
    chk_inv = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
